// File: rtl/vga_fb_pkg.sv
// Shared state type, default geometry and colour constants for the framebuffer scheduler.
package vga_fb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREFILL = 2'd1,
      RUN     = 2'd2
   } sched_state_t;

   localparam int H_ACTIVE_DFLT = 640;
   localparam int V_ACTIVE_DFLT = 480;
   localparam int PIX_TOTAL     = H_ACTIVE_DFLT * V_ACTIVE_DFLT;

   localparam logic [7:0] DEFAULT_COLOR = 8'h00;

   function automatic int pix_total(input int h_active, input int v_active);
      return h_active * v_active;
   endfunction

endpackage

// File: rtl/vga_fb_scheduler_if.sv
// Display, writer and framebuffer-RAM signals of the scheduler; master is the scheduler side.
interface vga_fb_scheduler_if
   import vga_fb_pkg::*;
#(
   parameter int ADDR_W = $clog2(PIX_TOTAL),
   parameter int DATA_W = 8
);

   logic              need_pixel;
   logic [DATA_W-1:0] colors;
   logic              underflow;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  need_pixel, wr_valid, wr_addr, wr_data, mem_rdata,
      output colors, underflow, wr_ready, mem_addr, mem_we, mem_wdata
   );

   modport slave (
      output need_pixel, wr_valid, wr_addr, wr_data, mem_rdata,
      input  colors, underflow, wr_ready, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/vga_pixel_fifo.sv
// Show-ahead pixel FIFO: head is valid combinationally whenever count > 0.
// Flush beats push/pop; the caller guarantees no push when full and no pop when empty.
module vga_pixel_fifo
   import vga_fb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wp;
   logic [AW-1:0]     rp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: head is only consumed while count > 0.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wp] <= din;
   end

   assign head = mem[rp];

endmodule

// File: rtl/vga_fb_scheduler.sv
// Framebuffer scan-out scheduler: prefetches pixels into a show-ahead FIFO and shares one RAM port.
// Display reads have strict priority; the writer is granted every cycle without a display read.
module vga_fb_scheduler
   import vga_fb_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DFLT,
   parameter int V_ACTIVE   = V_ACTIVE_DFLT,
   parameter int ADDR_W     = $clog2(PIX_TOTAL),
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LATENCY = 1
) (
   input  logic                clk25MHz,
   input  logic                rst,
   input  logic                en,
   input  logic                frame_start,
   vga_fb_scheduler_if.master  bus
);

   localparam int              FRAME_PIX = pix_total(H_ACTIVE, V_ACTIVE);
   localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
   // One extra bit so a frame that exactly fills the address space still compares correctly.
   localparam logic [ADDR_W:0] FRAME_END = (ADDR_W+1)'(FRAME_PIX);

   sched_state_t          state_q;
   sched_state_t          state_d;
   logic [ADDR_W-1:0]     rd_ptr;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [RD_LATENCY-1:0] vpipe;
   logic                  underflow_q;

   logic [CW-1:0]         count;
   logic [CW-1:0]         inflight;
   logic [CW:0]           occupancy;
   logic [DATA_W-1:0]     fifo_head;

   logic                  in_run;
   logic                  fetching;
   logic                  pop;
   logic                  disp_issue;
   logic                  xfer;
   logic                  wr_in_range;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_flush;

   assign in_run   = (state_q == RUN);
   assign fetching = (state_q == PREFILL) || in_run;
   assign pop      = en & in_run & bus.need_pixel & (count != '0);

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CW'(vpipe[i]);
      end
   end

   // Reserve a FIFO slot for every read still in the RAM pipeline so a push can never overflow.
   assign occupancy  = {1'b0, count} + {1'b0, inflight} - (CW+1)'(pop);
   assign disp_issue = en & fetching
                     & ({1'b0, rd_ptr} < FRAME_END)
                     & (occupancy < (CW+1)'(FIFO_DEPTH));

   assign bus.wr_ready = en & ~rst & ~disp_issue;
   assign xfer         = bus.wr_valid & bus.wr_ready;
   assign wr_in_range  = ({1'b0, bus.wr_addr} < FRAME_END);

   always_comb begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_we    = 1'b0;
      if (disp_issue) begin
         bus.mem_addr = rd_ptr;
      end else if (xfer) begin
         bus.mem_addr  = bus.wr_addr;
         bus.mem_wdata = bus.wr_data;
         bus.mem_we    = wr_in_range;
      end
   end

   assign bus.colors    = (in_run && count != '0) ? fifo_head : DATA_W'(DEFAULT_COLOR);
   assign bus.underflow = underflow_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = IDLE;
         PREFILL: if (count == CW'(FIFO_DEPTH)) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (frame_start) state_d = PREFILL;
   end

   always_ff @(posedge clk25MHz or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_ptr      <= '0;
         vpipe       <= '0;
         underflow_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else if (en) begin
         state_q <= state_d;
         addr_q  <= bus.mem_addr;
         wdata_q <= bus.mem_wdata;
         if (frame_start) begin
            // Clearing the valid pipe discards returns of reads issued for the old frame.
            rd_ptr      <= '0;
            vpipe       <= '0;
            underflow_q <= 1'b0;
         end else begin
            if (disp_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
            vpipe <= (vpipe << 1) | RD_LATENCY'(disp_issue);
            if (in_run && bus.need_pixel && count == '0) underflow_q <= 1'b1;
         end
      end
   end

   assign fifo_push  = en & ~frame_start & vpipe[RD_LATENCY-1];
   assign fifo_pop   = pop & ~frame_start;
   assign fifo_flush = en & frame_start;

   vga_pixel_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk25MHz),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (bus.mem_rdata),
      .head  (fifo_head),
      .count (count)
   );

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler on a 4x2 frame: directed steps, then random traffic against a queue model.
module tb_vga_fb_scheduler;

   localparam int NPIX  = 8;
   localparam int DEPTH = 4;
   localparam int LAT   = 1;
   localparam int S_IDLE = 0, S_PRE = 1, S_RUN = 2;

   logic clk25MHz;
   logic rst;
   logic en;
   logic frame_start;

   vga_fb_scheduler_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   vga_fb_scheduler #(
      .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(4), .DATA_W(8),
      .FIFO_DEPTH(DEPTH), .RD_LATENCY(LAT)
   ) dut (
      .clk25MHz    (clk25MHz),
      .rst         (rst),
      .en          (en),
      .frame_start (frame_start),
      .bus         (bus)
   );

   initial clk25MHz = 1'b0;
   always #5 clk25MHz = ~clk25MHz;

   // Framebuffer RAM: one-cycle read latency, preloaded with address + 8'h10 while in reset.
   logic [7:0] ram [16];
   always @(posedge clk25MHz) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) ram[i] <= 8'(i + 16);
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int tests = 0;
   int fails = 0;

   // Reference model: pixels available, reads in flight, frame progress.
   int         m_state = S_IDLE;
   int         m_rd = 0;
   bit         m_under = 1'b0;
   logic [3:0] m_addr = '0;
   logic [7:0] m_wdata = '0;
   logic [7:0] m_fifo [$];
   int         p_left [$];
   logic [7:0] p_val [$];

   logic [3:0] rd_log [$];
   logic [7:0] col_log [$];
   int         we_cnt = 0;
   bit         wr_acc = 1'b0;
   bit         wr_pend = 1'b0;
   logic [3:0] wr_a = '0;
   logic [7:0] wr_d = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_cycle();
      int         cnt, infl;
      bit         popv, iss, rdy, xfer, we_e;
      logic [7:0] col_e, wd_e;
      logic [3:0] addr_e;
      cnt    = m_fifo.size();
      infl   = p_left.size();
      popv   = en && m_state == S_RUN && bus.need_pixel && cnt > 0;
      iss    = en && m_state != S_IDLE && m_rd < NPIX && (cnt + infl - int'(popv)) < DEPTH;
      rdy    = en && !iss;
      xfer   = bus.wr_valid && rdy;
      we_e   = xfer && (int'(bus.wr_addr) < NPIX);
      col_e  = (m_state == S_RUN && cnt > 0) ? m_fifo[0] : 8'h00;
      addr_e = iss ? 4'(m_rd) : (xfer ? bus.wr_addr : m_addr);
      wd_e   = (!iss && xfer) ? bus.wr_data : m_wdata;

      check("colors",    bus.colors,    col_e);
      check("wr_ready",  bus.wr_ready,  rdy);
      check("mem_we",    bus.mem_we,    we_e);
      check("mem_addr",  bus.mem_addr,  addr_e);
      check("mem_wdata", bus.mem_wdata, wd_e);
      check("underflow", bus.underflow, m_under);

      if (en && !bus.wr_ready) rd_log.push_back(bus.mem_addr);
      if (en && bus.need_pixel) col_log.push_back(bus.colors);
      if (bus.mem_we) we_cnt++;
      if (bus.wr_valid && bus.wr_ready) begin
         wr_acc  = 1'b1;
         wr_pend = 1'b0;
      end

      if (en) begin
         m_addr  = addr_e;
         m_wdata = wd_e;
         if (frame_start) begin
            m_fifo.delete();
            p_left.delete();
            p_val.delete();
            m_rd    = 0;
            m_under = 1'b0;
            m_state = S_PRE;
         end else begin
            if (m_state == S_RUN && bus.need_pixel && cnt == 0) m_under = 1'b1;
            if (m_state == S_PRE && cnt == DEPTH) m_state = S_RUN;
            if (popv) void'(m_fifo.pop_front());
            for (int i = 0; i < p_left.size(); i++) p_left[i] = p_left[i] - 1;
            while (p_left.size() > 0 && p_left[0] == 0) begin
               m_fifo.push_back(p_val.pop_front());
               void'(p_left.pop_front());
            end
            if (iss) begin
               p_left.push_back(LAT);
               p_val.push_back(ram[4'(m_rd)]);
               m_rd++;
            end
         end
      end
   endtask

   task automatic step(input bit fs, input bit np, input bit e);
      frame_start    = fs;
      bus.need_pixel = np;
      en             = e;
      bus.wr_valid   = wr_pend;
      bus.wr_addr    = wr_a;
      bus.wr_data    = wr_d;
      @(negedge clk25MHz);
      model_cycle();
      @(posedge clk25MHz);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; frame_start = 1'b0;
      bus.need_pixel = 1'b0; bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      repeat (2) @(posedge clk25MHz);
      #1;
      check("rst_colors",    bus.colors,    8'h00);
      check("rst_mem_we",    bus.mem_we,    1'b0);
      check("rst_mem_addr",  bus.mem_addr,  4'h0);
      check("rst_mem_wdata", bus.mem_wdata, 8'h00);
      check("rst_wr_ready",  bus.wr_ready,  1'b0);
      check("rst_underflow", bus.underflow, 1'b0);
      rst = 1'b0;
      repeat (2) step(0, 0, 1);

      // Frame 1 prefill: four consecutive reads, then RUN with head 8'h10.
      rd_log.delete();
      step(1, 0, 1);
      repeat (6) step(0, 0, 1);
      check("prefill_reads", rd_log.size(), 4);
      for (int i = 0; i < 4; i++) check("prefill_addr", rd_log[i], i);
      check("run_head", bus.colors, 8'h10);

      // Scan-out burst with a competing writer at pixel 5.
      rd_log.delete(); col_log.delete(); we_cnt = 0;
      wr_pend = 1'b1; wr_a = 4'd5; wr_d = 8'hAA;
      repeat (8) step(0, 1, 1);
      wr_pend = 1'b0;
      check("burst_len", col_log.size(), 8);
      for (int i = 0; i < 8; i++) check("burst_pixel", col_log[i], 8'h10 + i);
      check("burst_underflow", bus.underflow, 1'b0);
      check("burst_reads", rd_log.size(), 4);
      check("burst_last_read", rd_log[3], 4'd7);
      check("burst_we_once", we_cnt, 1);
      check("ram5_written", ram[5], 8'hAA);

      // Past end of frame the FIFO runs dry.
      step(0, 1, 1);
      check("drain_colors", col_log[col_log.size()-1], 8'h00);
      check("drain_underflow", bus.underflow, 1'b1);

      // Frame 2 sees the written pixel.
      step(1, 0, 1);
      check("fs_clears_underflow", bus.underflow, 1'b0);
      repeat (6) step(0, 0, 1);
      col_log.delete();
      repeat (8) step(0, 1, 1);
      check("f2_pixel0", col_log[0], 8'h10);
      check("f2_pixel4", col_log[4], 8'h14);
      check("f2_pixel5", col_log[5], 8'hAA);
      check("f2_pixel7", col_log[7], 8'h17);

      // Restart while reads are in flight.
      step(1, 0, 1);
      repeat (2) step(0, 0, 1);
      step(1, 0, 1);
      rd_log.delete();
      repeat (6) step(0, 0, 1);
      check("restart_reads", rd_log.size(), 4);
      check("restart_addr0", rd_log[0], 4'd0);
      check("restart_head", bus.colors, 8'h10);

      // Enable low mid-RUN freezes everything; an out-of-range write is later dropped.
      repeat (2) step(0, 1, 1);
      wr_pend = 1'b1; wr_a = 4'd9; wr_d = 8'h55; we_cnt = 0; wr_acc = 1'b0;
      repeat (3) step(0, 1, 0);
      check("en0_colors", bus.colors, 8'h12);
      check("en0_no_accept", wr_acc, 1'b0);
      repeat (8) step(0, 1, 1);
      check("oor_accepted", wr_acc, 1'b1);
      check("oor_no_we", we_cnt, 0);
      check("ram9_intact", ram[9], 8'h19);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         wr_pend = 1'($urandom_range(0, 1));
         wr_a    = 4'($urandom_range(0, 11));
         wr_d    = 8'($urandom_range(1, 255));
         step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
